// File: rtl/io_timer_irq.sv
// Bus-mapped 16-bit down-counter with reload latch, sticky timer/NMI flags,
// a registered read port and level irq/nmi outputs.
module io_timer_irq #(
    parameter logic [15:0] RESET_LATCH = 16'hFFFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ready,
    input  logic       cs,
    input  logic [2:0] addr,
    input  logic       write,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       irq,
    output logic       nmi
);

    localparam logic [2:0] A_TLO  = 3'd0;
    localparam logic [2:0] A_THI  = 3'd1;
    localparam logic [2:0] A_CTRL = 3'd2;
    localparam logic [2:0] A_STAT = 3'd3;
    localparam logic [2:0] A_NMI  = 3'd4;

    logic [15:0] count_q, count_d;
    logic [15:0] latch_q, latch_d;
    logic        run_q, run_d;
    logic        cont_q, cont_d;
    logic        ien_q, ien_d;
    logic        tf_q, tf_d;
    logic        nf_q, nf_d;
    logic [7:0]  data_q, data_d;

    logic        wr_en;
    logic        rd_en;
    logic        tick;
    logic        underflow;
    logic [7:0]  rd_val;

    assign wr_en     = cs & ready & write;
    assign rd_en     = cs & ready & ~write;
    assign tick      = run_q & ready;
    assign underflow = tick & (count_q == 16'h0000);

    // Reads sample the state before this edge's update (pre-decrement count).
    always_comb begin
        rd_val = 8'h00;
        case (addr)
            A_TLO:   rd_val = count_q[7:0];
            A_THI:   rd_val = count_q[15:8];
            A_CTRL:  rd_val = {5'b0, ien_q, cont_q, run_q};
            A_STAT:  rd_val = {6'b0, nf_q, tf_q};
            default: rd_val = 8'h00;
        endcase
    end

    always_comb begin
        count_d = count_q;
        latch_d = latch_q;
        run_d   = run_q;
        cont_d  = cont_q;
        ien_d   = ien_q;
        tf_d    = tf_q;
        nf_d    = nf_q;
        data_d  = rd_en ? rd_val : data_q;

        if (tick) begin
            count_d = underflow ? latch_q : count_q - 16'd1;
        end
        if (underflow && !cont_q) begin
            run_d = 1'b0;
        end

        if (wr_en) begin
            case (addr)
                A_TLO: latch_d[7:0] = data_i;
                A_THI: begin
                    latch_d[15:8] = data_i;
                    if (!run_q) begin
                        count_d = {data_i, latch_q[7:0]};
                    end
                end
                // A CTRL write overrides the one-shot auto-stop on the same edge.
                A_CTRL: begin
                    if (!run_q && data_i[0]) begin
                        count_d = latch_q;
                    end
                    run_d  = data_i[0];
                    cont_d = data_i[1];
                    ien_d  = data_i[2];
                end
                A_STAT: begin
                    if (data_i[0]) tf_d = 1'b0;
                    if (data_i[1]) nf_d = 1'b0;
                end
                A_NMI:   nf_d = 1'b1;
                default: ;
            endcase
        end

        // Setting wins over a simultaneous write-one-to-clear.
        if (underflow) begin
            tf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= 16'hFFFF;
            latch_q <= RESET_LATCH;
            run_q   <= 1'b0;
            cont_q  <= 1'b0;
            ien_q   <= 1'b0;
            tf_q    <= 1'b0;
            nf_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            count_q <= count_d;
            latch_q <= latch_d;
            run_q   <= run_d;
            cont_q  <= cont_d;
            ien_q   <= ien_d;
            tf_q    <= tf_d;
            nf_q    <= nf_d;
            data_q  <= data_d;
        end
    end

    assign data_o = data_q;
    assign irq    = tf_q & ien_q;
    assign nmi    = nf_q;

endmodule

// File: tb/tb_io_timer_irq.sv
// Directed and randomized bus traffic for io_timer_irq, checked against a
// rule-level timer model after every clock edge.
module tb_io_timer_irq;

    logic       clk = 1'b0;
    logic       reset;
    logic       ready;
    logic       cs;
    logic [2:0] addr;
    logic       write;
    logic [7:0] data_i;
    logic [7:0] data_o;
    logic       irq;
    logic       nmi;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_count, m_latch;
    logic        m_run, m_cont, m_ien, m_tf, m_nf;
    logic [7:0]  m_data;

    io_timer_irq #(.RESET_LATCH(16'hFFFF)) dut (
        .clk    (clk),
        .reset  (reset),
        .ready  (ready),
        .cs     (cs),
        .addr   (addr),
        .write  (write),
        .data_i (data_i),
        .data_o (data_o),
        .irq    (irq),
        .nmi    (nmi)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 16'hFFFF;
        m_latch = 16'hFFFF;
        m_run   = 1'b0;
        m_cont  = 1'b0;
        m_ien   = 1'b0;
        m_tf    = 1'b0;
        m_nf    = 1'b0;
        m_data  = 8'h00;
    endtask

    function automatic logic [7:0] m_reg(input logic [2:0] a);
        case (a)
            3'd0:    return m_count[7:0];
            3'd1:    return m_count[15:8];
            3'd2:    return {5'b0, m_ien, m_cont, m_run};
            3'd3:    return {6'b0, m_nf, m_tf};
            default: return 8'h00;
        endcase
    endfunction

    // Apply one clock edge of the timer rules to the model.
    task automatic model_edge(input logic rdy, input logic c, input logic [2:0] a,
                              input logic w, input logic [7:0] d);
        logic [15:0] n_count, n_latch;
        logic        n_run, n_cont, n_ien, n_tf, n_nf;
        logic        ticked, under;
        n_count = m_count; n_latch = m_latch;
        n_run = m_run; n_cont = m_cont; n_ien = m_ien; n_tf = m_tf; n_nf = m_nf;
        ticked = m_run && rdy;
        under  = ticked && (m_count == 0);
        if (c && rdy && !w) m_data = m_reg(a);
        if (ticked) n_count = under ? m_latch : m_count - 1;
        if (under && !m_cont) n_run = 1'b0;
        if (c && rdy && w) begin
            case (a)
                3'd0: n_latch[7:0] = d;
                3'd1: begin
                    n_latch[15:8] = d;
                    if (!m_run) n_count = {d, m_latch[7:0]};
                end
                3'd2: begin
                    if (!m_run && d[0]) n_count = m_latch;
                    n_run = d[0]; n_cont = d[1]; n_ien = d[2];
                end
                3'd3: begin
                    n_tf = m_tf & ~d[0];
                    n_nf = m_nf & ~d[1];
                end
                3'd4: n_nf = 1'b1;
                default: ;
            endcase
        end
        if (under) n_tf = 1'b1;
        m_count = n_count; m_latch = n_latch;
        m_run = n_run; m_cont = n_cont; m_ien = n_ien; m_tf = n_tf; m_nf = n_nf;
    endtask

    task automatic cycle(input logic rdy, input logic c, input logic [2:0] a,
                         input logic w, input logic [7:0] d);
        ready = rdy; cs = c; addr = a; write = w; data_i = d;
        @(posedge clk);
        model_edge(rdy, c, a, w, d);
        #1;
        check("data_o", data_o, m_data);
        check("irq", {7'b0, irq}, {7'b0, m_tf & m_ien});
        check("nmi", {7'b0, nmi}, {7'b0, m_nf});
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cycle(1'b1, 1'b1, a, 1'b1, d);
    endtask

    task automatic rd(input logic [2:0] a);
        cycle(1'b1, 1'b1, a, 1'b0, 8'h00);
    endtask

    task automatic idle(input logic rdy);
        cycle(rdy, 1'b0, 3'd0, 1'b0, 8'h00);
    endtask

    initial begin
        reset = 1'b0; ready = 1'b0; cs = 1'b0; addr = 3'd0; write = 1'b0; data_i = 8'h00;
        model_reset();
        #1;
        check("reset_data_o", data_o, 8'h00);
        check("reset_irq", {7'b0, irq}, 8'h00);
        check("reset_nmi", {7'b0, nmi}, 8'h00);
        #1 reset = 1'b1;

        // Continuous mode, period 4, irq enabled
        wr(3'd0, 8'h03);
        wr(3'd1, 8'h00);
        wr(3'd2, 8'h07);
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("cont_irq_before_4th", {7'b0, irq}, 8'h00);
        idle(1'b1);
        check("cont_irq_4th_tick", {7'b0, irq}, 8'h01);
        rd(3'd0);
        check("cont_reload", data_o, 8'h03);
        for (int i = 0; i < 6; i++) rd(3'd0);
        wr(3'd3, 8'h01);
        wr(3'd2, 8'h00);

        // One-shot mode
        wr(3'd2, 8'h05);
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("oneshot_irq", {7'b0, irq}, 8'h01);
        for (int i = 0; i < 3; i++) idle(1'b1);
        rd(3'd2);
        check("oneshot_ctrl", data_o, 8'h04);
        rd(3'd0);
        check("oneshot_count", data_o, 8'h03);
        wr(3'd3, 8'h01);
        check("oneshot_irq_clr", {7'b0, irq}, 8'h00);

        // Sparse ready, ien off
        wr(3'd0, 8'h02);
        wr(3'd1, 8'h00);
        wr(3'd2, 8'h03);
        for (int i = 0; i < 9; i++) idle(i % 3 == 0);
        check("sparse_irq", {7'b0, irq}, 8'h00);
        cycle(1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
        rd(3'd3);
        check("sparse_tf", data_o, 8'h01);

        // NMI trigger / clear, and STAT clear racing an underflow
        wr(3'd4, 8'h5A);
        check("nmi_set", {7'b0, nmi}, 8'h01);
        wr(3'd3, 8'h02);
        check("nmi_clr", {7'b0, nmi}, 8'h00);
        wr(3'd2, 8'h00);
        wr(3'd0, 8'h00);
        wr(3'd1, 8'h00);
        wr(3'd2, 8'h07);
        wr(3'd3, 8'h01);
        check("stat_clr_vs_underflow", {7'b0, irq}, 8'h01);
        rd(3'd3);
        rd(3'd6);
        check("reserved_read", data_o, 8'h00);

        // Async reset mid-count with irq, nmi and data_o all non-zero
        wr(3'd0, 8'h40);
        wr(3'd4, 8'h00);
        rd(3'd2);
        check("pre_reset_data", data_o, 8'h07);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("async_data_o", data_o, 8'h00);
        check("async_irq", {7'b0, irq}, 8'h00);
        check("async_nmi", {7'b0, nmi}, 8'h00);
        #1 reset = 1'b1;
        rd(3'd0);
        check("post_reset_tlo", data_o, 8'hFF);
        rd(3'd1);
        check("post_reset_thi", data_o, 8'hFF);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic       r_rdy, r_cs, r_w;
            logic [2:0] r_a;
            logic [7:0] r_d;
            r_rdy = ($urandom_range(0, 3) != 0);
            r_cs  = ($urandom_range(0, 2) == 0);
            r_a   = 3'($urandom_range(0, 7));
            r_w   = 1'($urandom_range(0, 1));
            r_d   = 8'($urandom);
            if (r_a == 3'd0 && r_d[7]) r_d = {4'h0, r_d[3:0]};
            if (r_a == 3'd1 && r_d[0]) r_d = 8'h00;
            cycle(r_rdy, r_cs, r_a, r_w, r_d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
